// File: rtl/chip_gate2_tester.sv
// Exhaustive 2-input gate tester: drives all four A/B vectors to NGATES gates in parallel,
// waits SETTLE cycles through a 2-flop synchroniser, and accumulates per-gate mismatches.
module chip_gate2_tester #(
    parameter int unsigned NGATES = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic [2:0]        Mode,
    input  logic              DISP_RSLT,
    output logic [NGATES-1:0] A_out,
    output logic [NGATES-1:0] B_out,
    input  logic [NGATES-1:0] Y_in,
    output logic              Busy,
    output logic              Done,
    output logic              RSLT,
    output logic [NGATES-1:0] Fail_mask
);

    // state | meaning: HALTED idle | SET latch mode | DRIVE apply vec | SETTLE wait | SAMPLE compare | DONE hold result
    typedef enum logic [2:0] {
        S_HALTED, S_SET, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [1:0]        vec_q, vec_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rslt_q, rslt_d;
    logic [NGATES-1:0] mask_q, mask_d;
    logic [NGATES-1:0] y_meta_q, y_sync_q;
    logic              exp_bit;
    logic [NGATES-1:0] mismatch;
    logic              driving;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_HALTED;
            mode_q   <= 3'd0;
            vec_q    <= 2'd0;
            cnt_q    <= 8'd0;
            rslt_q   <= 1'b0;
            mask_q   <= '0;
            y_meta_q <= '0;
            y_sync_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            rslt_q   <= rslt_d;
            mask_q   <= mask_d;
            y_meta_q <= Y_in;
            y_sync_q <= y_meta_q;
        end
    end

    always_comb begin
        exp_bit = 1'b0;
        case (mode_q)
            3'd0:    exp_bit = vec_q[1] & vec_q[0];
            3'd1:    exp_bit = ~(vec_q[1] & vec_q[0]);
            3'd2:    exp_bit = vec_q[1] | vec_q[0];
            3'd3:    exp_bit = ~(vec_q[1] | vec_q[0]);
            3'd4:    exp_bit = vec_q[1] ^ vec_q[0];
            3'd5:    exp_bit = ~(vec_q[1] ^ vec_q[0]);
            default: exp_bit = 1'b0;
        endcase
    end

    assign mismatch = y_sync_q ^ {NGATES{exp_bit}};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        rslt_d  = rslt_q;
        mask_d  = mask_q;
        case (state_q)
            S_HALTED: begin
                if (Run) state_d = S_SET;
            end
            S_SET: begin
                mode_d = Mode;
                vec_d  = 2'd0;
                if (Mode > 3'd5) begin
                    state_d = S_DONE;
                    rslt_d  = 1'b0;
                    mask_d  = '1;
                end else begin
                    state_d = S_DRIVE;
                    rslt_d  = 1'b1;
                    mask_d  = '0;
                end
            end
            S_DRIVE: begin
                cnt_d   = SETTLE_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) state_d = S_SAMPLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_SAMPLE: begin
                mask_d = mask_q | mismatch;
                if (|mismatch) rslt_d = 1'b0;
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                if (DISP_RSLT) state_d = S_HALTED;
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_comb begin
        Busy    = (state_q == S_SET) || (state_q == S_DRIVE) ||
                  (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        Done    = (state_q == S_DONE) || ((state_q == S_SAMPLE) && (vec_q == 2'd3));
        driving = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        A_out   = driving ? {NGATES{vec_q[1]}} : '0;
        B_out   = driving ? {NGATES{vec_q[0]}} : '0;
        RSLT    = rslt_q;
        Fail_mask = mask_q;
    end

endmodule

// File: tb/tb_chip_gate2_tester.sv
// Bench for chip_gate2_tester: behavioural device/tester model, vector table, random runs
// and hand sequences for reset, early acknowledge, held Run and a 6-gate/5-settle instance.
module tb_chip_gate2_tester;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int N6 = 6;
    localparam int S6 = 5;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Run, DISP_RSLT;
    logic [2:0]   Mode;
    logic [N-1:0] A_out, B_out, Y_in, Fail_mask;
    logic         Busy, Done, RSLT;

    logic          run6, disp6;
    logic [2:0]    mode6;
    logic [N6-1:0] a6, b6, y6, mask6;
    logic          busy6, done6, rslt6;

    logic [2:0]   dev_mode;
    logic [N-1:0] stuck1, stuck0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    chip_gate2_tester #(.NGATES(N), .SETTLE(S)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Mode(Mode), .DISP_RSLT(DISP_RSLT),
        .A_out(A_out), .B_out(B_out), .Y_in(Y_in), .Busy(Busy), .Done(Done),
        .RSLT(RSLT), .Fail_mask(Fail_mask)
    );

    chip_gate2_tester #(.NGATES(N6), .SETTLE(S6)) u_dut6 (
        .Clk(Clk), .Reset_n(Reset_n), .Run(run6), .Mode(mode6), .DISP_RSLT(disp6),
        .A_out(a6), .B_out(b6), .Y_in(y6), .Busy(busy6), .Done(done6),
        .RSLT(rslt6), .Fail_mask(mask6)
    );

    // truth table indexed by {a,b}
    function automatic logic [3:0] truth(input logic [2:0] m);
        case (m)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b0111;
            3'd2:    return 4'b1110;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic gate_out(input logic [2:0] m, input logic a, input logic b);
        logic [3:0] t;
        t = truth(m);
        return t[{a, b}];
    endfunction

    function automatic logic [N-1:0] device(input logic [2:0] dm, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic [N-1:0] s1,
                                            input logic [N-1:0] s0);
        logic [N-1:0] y;
        for (int g = 0; g < N; g++) y[g] = gate_out(dm, a[g], b[g]);
        return (y & ~s0) | s1;
    endfunction

    assign Y_in = device(dev_mode, A_out, B_out, stuck1, stuck0);
    assign y6   = a6 & b6;

    task automatic model(input logic [2:0] m, input logic [2:0] dm, input logic [N-1:0] s1,
                         input logic [N-1:0] s0, output logic r, output logic [N-1:0] mk,
                         output int dc);
        logic a, b, e;
        if (m > 3'd5) begin
            r  = 1'b0;
            mk = '1;
            dc = 1;
        end else begin
            mk = '0;
            for (int v = 0; v < 4; v++) begin
                a  = (v >= 2);
                b  = (v % 2) == 1;
                e  = gate_out(m, a, b);
                mk = mk | (device(dm, {N{a}}, {N{b}}, s1, s0) ^ {N{e}});
            end
            r  = (mk == '0);
            dc = 4 * (S + 2) + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is 1 time unit after a rising edge with the DUT in Halted.
    task automatic run_test(input logic [2:0] m, input logic [2:0] dm, input logic [N-1:0] s1,
                            input logic [N-1:0] s0, input logic er, input logic [N-1:0] em,
                            input int ed, input bit toggle, input bit hold_disp, input string tag);
        int done_at;
        logic [1:0] vi;
        dev_mode = dm;
        stuck1   = s1;
        stuck0   = s0;
        Mode     = m;
        Run      = 1'b1;
        @(posedge Clk); #1;
        chk({tag, " set_busy"}, 32'(Busy), 32'd1);
        chk({tag, " set_ab_zero"}, 32'({A_out, B_out}), 32'd0);
        if (!toggle) Run = 1'b0;
        if (hold_disp) DISP_RSLT = 1'b1;
        done_at = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge Clk); #1;
            if (toggle) Mode = 3'($urandom);
            if (m <= 3'd5 && (cyc - 1) % (S + 2) == 0 && cyc < 1 + 4 * (S + 2)) begin
                vi = 2'((cyc - 1) / (S + 2));
                chk({tag, " a_out"}, 32'(A_out), 32'({N{vi[1]}}));
                chk({tag, " b_out"}, 32'(B_out), 32'({N{vi[0]}}));
            end
            if (Done && !Busy) begin
                done_at = cyc;
                break;
            end
        end
        chk({tag, " done_cycle"}, 32'(done_at), 32'(ed));
        chk({tag, " rslt"}, 32'(RSLT), 32'(er));
        chk({tag, " fail_mask"}, 32'(Fail_mask), 32'(em));
        chk({tag, " done_ab_zero"}, 32'({A_out, B_out}), 32'd0);
        if (hold_disp) begin
            @(posedge Clk); #1;
            DISP_RSLT = 1'b0;
            chk({tag, " halted_after_ack"}, 32'({Done, Busy}), 32'd0);
            chk({tag, " rslt_held"}, 32'(RSLT), 32'(er));
        end else begin
            @(posedge Clk); #1;
            chk({tag, " done_holds"}, 32'({Done, Busy}), 32'b10);
            DISP_RSLT = 1'b1;
            @(posedge Clk); #1;
            DISP_RSLT = 1'b0;
            chk({tag, " halted_after_ack"}, 32'({Done, Busy}), 32'd0);
            chk({tag, " rslt_held"}, 32'(RSLT), 32'(er));
            chk({tag, " mask_held"}, 32'(Fail_mask), 32'(em));
            if (toggle) begin
                @(posedge Clk); #1;
                chk({tag, " restart_set"}, 32'(Busy), 32'd1);
                Run = 1'b0;
                done_at = -1;
                for (int cyc = 1; cyc <= 200; cyc++) begin
                    @(posedge Clk); #1;
                    if (Done && !Busy) begin
                        done_at = cyc;
                        break;
                    end
                end
                chk({tag, " second_done_seen"}, 32'(done_at > 0), 32'd1);
                DISP_RSLT = 1'b1;
                @(posedge Clk); #1;
                DISP_RSLT = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [2:0]   mode;
        logic [2:0]   dmode;
        logic [N-1:0] s1;
        logic [N-1:0] s0;
        logic         exp_r;
        logic [N-1:0] exp_m;
        int           exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         r_exp;
        logic [N-1:0] m_exp;
        int           d_exp;
        logic [2:0]   rm, rdm;
        logic [N-1:0] rs1, rs0;
        int           done_at;
        logic [1:0]   vi;

        tbl[0] = '{3'd4, 3'd4, 4'b0000, 4'b0000, 1'b1, 4'b0000, 17};
        tbl[1] = '{3'd1, 3'd1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 17};
        tbl[2] = '{3'd7, 3'd0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1};
        tbl[3] = '{3'd6, 3'd0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1};
        tbl[4] = '{3'd0, 3'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 17};
        tbl[5] = '{3'd2, 3'd3, 4'b0000, 4'b0000, 1'b0, 4'b1111, 17};
        tbl[6] = '{3'd5, 3'd5, 4'b0000, 4'b0001, 1'b0, 4'b0001, 17};
        tbl[7] = '{3'd3, 3'd3, 4'b1000, 4'b0010, 1'b0, 4'b1010, 17};

        Reset_n = 1'b0; Run = 1'b0; Mode = 3'd0; DISP_RSLT = 1'b0;
        run6 = 1'b0; mode6 = 3'd0; disp6 = 1'b0;
        dev_mode = 3'd0; stuck1 = '0; stuck0 = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset ab", 32'({A_out, B_out}), 32'd0);
        chk("reset busy_done", 32'({Busy, Done}), 32'd0);
        chk("reset rslt_mask", 32'({RSLT, Fail_mask}), 32'd0);
        chk("reset dut6", 32'({busy6, done6, rslt6, mask6}), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("post_reset halted", 32'({Busy, Done}), 32'd0);

        for (int i = 0; i < 8; i++)
            run_test(tbl[i].mode, tbl[i].dmode, tbl[i].s1, tbl[i].s0, tbl[i].exp_r,
                     tbl[i].exp_m, tbl[i].exp_done, 1'b0, 1'b0, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            rm  = 3'($urandom_range(0, 7));
            rdm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5))
                                              : ((rm <= 3'd5) ? rm : 3'd0);
            rs1 = 4'($urandom & $urandom & $urandom);
            rs0 = 4'($urandom & $urandom) & ~rs1;
            model(rm, rdm, rs1, rs0, r_exp, m_exp, d_exp);
            run_test(rm, rdm, rs1, rs0, r_exp, m_exp, d_exp, 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        run_test(3'd4, 3'd4, '0, '0, 1'b1, '0, 17, 1'b1, 1'b0, "toggle");
        run_test(3'd1, 3'd1, 4'b0100, '0, 1'b0, 4'b0100, 17, 1'b0, 1'b1, "disp_early");

        run_test(3'd5, 3'd5, '0, '0, 1'b1, '0, 17, 1'b0, 1'b0, "pre_reset");
        dev_mode = 3'd4; stuck1 = '0; stuck0 = '0;
        Mode = 3'd4;
        Run  = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        chk("midreset vec2_a", 32'(A_out), 32'hf);
        chk("midreset vec2_b", 32'(B_out), 32'h0);
        chk("midreset rslt_before", 32'(RSLT), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("midreset ab", 32'({A_out, B_out}), 32'd0);
        chk("midreset busy_done", 32'({Busy, Done}), 32'd0);
        chk("midreset rslt_mask", 32'({RSLT, Fail_mask}), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("midreset halted", 32'({Busy, Done, RSLT}), 32'd0);
        run_test(3'd4, 3'd4, '0, '0, 1'b1, '0, 17, 1'b0, 1'b0, "post_midreset");

        mode6 = 3'd0;
        run6  = 1'b1;
        @(posedge Clk); #1;
        chk("dut6 set_busy", 32'(busy6), 32'd1);
        run6 = 1'b0;
        done_at = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge Clk); #1;
            mode6 = 3'($urandom);
            if ((cyc - 1) % (S6 + 2) == 0 && cyc < 1 + 4 * (S6 + 2)) begin
                vi = 2'((cyc - 1) / (S6 + 2));
                chk("dut6 a_out", 32'(a6), 32'({N6{vi[1]}}));
                chk("dut6 b_out", 32'(b6), 32'({N6{vi[0]}}));
            end
            if (done6 && !busy6) begin
                done_at = cyc;
                break;
            end
        end
        chk("dut6 done_cycle", 32'(done_at), 32'd29);
        chk("dut6 rslt", 32'(rslt6), 32'd1);
        chk("dut6 mask", 32'(mask6), 32'd0);
        disp6 = 1'b1;
        @(posedge Clk); #1;
        disp6 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("dut6 halted", 32'({busy6, done6}), 32'd0);
            chk("dut6 rslt_held", 32'(rslt6), 32'd1);
            @(posedge Clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chip_gate2_tester.md
CHIP_GATE2_TESTER -- requirements
Module: chip_gate2_tester

Interface
REQ-001 Parameter NGATES, default 4: number of independent 2-input gates on the device under test, legal range 1..16.
REQ-002 Parameter SETTLE, default 2: cycles between driving a vector and sampling it, legal range 2..255.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  starts a test when sampled high in Halted.
REQ-006 Mode  input  3  gate function, latched in Set: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 invalid.
REQ-007 DISP_RSLT  input  1  result acknowledged; returns Done_s to Halted.
REQ-008 A_out  output  NGATES  A input drive, bit g to gate g.
REQ-009 B_out  output  NGATES  B input drive, bit g to gate g.
REQ-010 Y_in  input  NGATES  gate outputs read back from the device, asynchronous to Clk.
REQ-011 Busy  output  1  high in Set, Drive, Settle and Sample.
REQ-012 Done  output  1  high in Done_s, and in the final Sample cycle.
REQ-013 RSLT  output  1  1 = device passed every vector on every gate.
REQ-014 Fail_mask  output  NGATES  bit g = 1 when gate g mismatched on at least one vector.

Function
REQ-015 Y_in SHALL pass through a 2-flop synchroniser per bit before comparison; SETTLE counts these 2 flop delays.
REQ-016 States SHALL be Halted, Set, Drive, Settle, Sample and Done_s.
REQ-017 Halted: Run=1 -> Set; else stay.
REQ-018 Set, lasting 1 cycle: latch Mode, clear the 2-bit vector counter, set RSLT=1, set Fail_mask=0, then go to Drive; with invalid Mode go to Done_s instead, with RSLT=0 and Fail_mask all ones.
REQ-019 Drive, lasting 1 cycle: A_out = all bits of vec[1], B_out = all bits of vec[0]; load the settle counter with SETTLE-1; go to Settle.
REQ-020 Settle: hold A_out/B_out; decrement the counter; go to Sample when it reaches 0, so Settle lasts SETTLE cycles.
REQ-021 Sample, lasting 1 cycle: for each g, expected = f(Mode, vec[1], vec[0]); mismatch with synchronised Y_in[g] sets Fail_mask[g] (sticky OR) and clears RSLT.
REQ-022 Sample, continued: vec==3 -> Done_s; otherwise increment vec and go to Drive.
REQ-023 A_out and B_out SHALL be 0 in Halted, Set and Done_s.
REQ-024 Done_s: hold RSLT and Fail_mask; DISP_RSLT=1 -> Halted; else stay.
REQ-025 RSLT and Fail_mask SHALL hold their values through Halted until the next Set.
REQ-026 Timing with Set at cycle 0: vector i is driven at cycle 1+i*(SETTLE+2); Done_s is entered at cycle 4*(SETTLE+2)+1 (17 for SETTLE=2).
REQ-027 Run asserted outside Halted SHALL be ignored; Mode changes after Set SHALL have no effect.
REQ-028 A Sample that reaches vec==3 and a simultaneous DISP_RSLT=1 SHALL still enter Done_s; DISP_RSLT is acted on only in Done_s.
REQ-029 Run and DISP_RSLT both high in Done_s -> Halted; Set follows only if Run is still high in Halted.

Reset
REQ-030 Reset_n=0 SHALL immediately force state Halted, vec=0, settle counter 0, A_out=B_out=0, Busy=0, Done=0, RSLT=0, Fail_mask=0 and synchroniser flops 0.
REQ-031 Reset mid-test SHALL abort with no partial result retained.
REQ-032 Leaving reset SHALL occur on the first Clk edge after Reset_n rises, with the block in Halted.

Verification
REQ-033 Good 7486 model, Mode=4, NGATES=4, SETTLE=2; pulse Run -> vectors 00,01,10,11 driven at cycles 1,5,9,13; Done at cycle 17; RSLT=1; Fail_mask=0000.
REQ-034 Mode=1 with gate 2 stuck-at-1 -> RSLT=0, Fail_mask=0100 (only vector 11 fails); other gates clean.
REQ-035 Mode=7 -> Done_s at cycle 1; RSLT=0; Fail_mask=1111; A_out/B_out stay 0.
REQ-036 Reset_n low during Settle of vector 2 -> all outputs 0 at once; later Run gives a full clean test.
REQ-037 Run held high and Mode toggled throughout the test -> single test using the Mode latched in Set; after DISP_RSLT a second test starts on the next Halted cycle.
REQ-038 NGATES=6, SETTLE=5, Mode=0, good model -> Done at cycle 29; RSLT=1; RSLT held in Halted until the next Run.
